// File: rtl/tspi_tx_shift_if.sv
// Handshake and serial-pin bundle between a TX controller (master) and tspi_tx_shift (slave).
interface tspi_tx_shift_if #(
  parameter int unsigned DATA_W = 8
);
  logic              shift_en;
  logic [DATA_W-1:0] tx_data;
  logic              shift_cmpt;
  logic              spi_cs_n;
  logic              spi_sck;
  logic              spi_mosi;

  modport master (
    output shift_en,
    output tx_data,
    input  shift_cmpt,
    input  spi_cs_n,
    input  spi_sck,
    input  spi_mosi
  );

  modport slave (
    input  shift_en,
    input  tx_data,
    output shift_cmpt,
    output spi_cs_n,
    output spi_sck,
    output spi_mosi
  );
endinterface

// File: rtl/tspi_tx_shift.sv
// SPI mode-0 transmit shifter: one DATA_W word per shift_en request, SCK half-period CLK_DIV.
// Define TSPI_TX_LSB_FIRST_EN to send tx_data[0] first; MSB first otherwise.
module tspi_tx_shift #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic           clk,
  input  logic           rst,
  tspi_tx_shift_if.slave bus
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]        r_state;
  logic [DIV_W-1:0]  r_div;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_sck;
  logic              r_cs_n;
  logic              r_cmpt;

  logic              w_div_tc;
  logic              w_mosi;
  logic [DATA_W-1:0] w_shift_adv;

  assign w_div_tc = (r_div == DIV_LAST);

  // MOSI is taken straight from the outgoing end of the shift register, which is
  // cleared whenever the block is not shifting so MOSI idles low.
`ifdef TSPI_TX_LSB_FIRST_EN
  assign w_mosi      = r_shift[0];
  assign w_shift_adv = {1'b0, r_shift[DATA_W-1:1]};
`else
  assign w_mosi      = r_shift[DATA_W-1];
  assign w_shift_adv = {r_shift[DATA_W-2:0], 1'b0};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_div     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_sck     <= 1'b0;
      r_cs_n    <= 1'b1;
      r_cmpt    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.shift_en) begin
            r_state   <= ST_SHIFT;
            r_shift   <= bus.tx_data;
            r_cs_n    <= 1'b0;
            r_sck     <= 1'b0;
            r_div     <= '0;
            r_bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (!bus.shift_en) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_cs_n    <= 1'b1;
            r_sck     <= 1'b0;
            r_div     <= '0;
            r_bit_cnt <= '0;
          end else if (w_div_tc) begin
            r_div <= '0;
            if (r_sck) begin
              // Falling SCK edge: either finish the word or present the next bit.
              r_sck     <= 1'b0;
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
              if (r_bit_cnt == BIT_LAST) begin
                r_state <= ST_DONE;
                r_shift <= '0;
                r_cs_n  <= 1'b1;
                r_cmpt  <= 1'b1;
              end else begin
                r_shift <= w_shift_adv;
              end
            end else begin
              r_sck <= 1'b1;
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        ST_DONE: begin
          if (!bus.shift_en) begin
            r_state <= ST_IDLE;
            r_cmpt  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_shift <= '0;
          r_cs_n  <= 1'b1;
          r_sck   <= 1'b0;
          r_cmpt  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.shift_cmpt = r_cmpt;
  assign bus.spi_cs_n   = r_cs_n;
  assign bus.spi_sck    = r_sck;
  assign bus.spi_mosi   = w_mosi;

endmodule

// File: tb/tb_tspi_tx_shift.sv
// Self-checking bench for tspi_tx_shift: directed word table, corner sequences and a
// randomized run compared cycle by cycle against a word-level reference model.
module tb_tspi_tx_shift;

  localparam int unsigned DW0 = 8;
  localparam int unsigned CD0 = 4;
  localparam int unsigned DW1 = 16;
  localparam int unsigned CD1 = 1;
  localparam int L0 = 2 * CD0 * DW0;
  localparam int L1 = 2 * CD1 * DW1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tspi_tx_shift_if #(.DATA_W(DW0)) bus0 ();
  tspi_tx_shift_if #(.DATA_W(DW1)) bus1 ();

  tspi_tx_shift #(.DATA_W(DW0), .CLK_DIV(CD0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  tspi_tx_shift #(.DATA_W(DW1), .CLK_DIV(CD1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
    end
  endtask

  // {cs_n, sck, mosi, cmpt}
  function automatic logic [3:0] outs(input bit which);
    if (which) return {bus1.spi_cs_n, bus1.spi_sck, bus1.spi_mosi, bus1.shift_cmpt};
    return {bus0.spi_cs_n, bus0.spi_sck, bus0.spi_mosi, bus0.shift_cmpt};
  endfunction

  // Reference model for DUT0: mode 0 idle, 1 sending (k cycles since start edge), 2 done.
  int            m_mode = 0;
  int            m_k    = 0;
  logic [DW0-1:0] m_word = '0;
  bit            chk_en = 1'b0;

  function automatic logic [3:0] model_out();
    int   idx;
    logic b;
    if (m_mode == 1) begin
      idx = m_k / (2 * CD0);
`ifdef TSPI_TX_LSB_FIRST_EN
      b = m_word[idx];
`else
      b = m_word[DW0 - 1 - idx];
`endif
      return {1'b0, 1'((m_k / CD0) % 2), b, 1'b0};
    end
    if (m_mode == 2) return 4'b1001;
    return 4'b1000;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0;
      chk_en = 1'b1;
    end else begin
      case (m_mode)
        0: if (bus0.shift_en) begin
             m_mode = 1;
             m_k    = 0;
             m_word = bus0.tx_data;
           end
        1: if (!bus0.shift_en) m_mode = 0;
           else begin
             m_k++;
             if (m_k == L0) m_mode = 2;
           end
        default: if (!bus0.shift_en) m_mode = 0;
      endcase
    end
    #1;
    if (chk_en) check("model_cycle", 32'(outs(0)), 32'(model_out()));
  end

  task automatic start(input bit which, input logic [31:0] d);
    @(negedge clk);
    if (which) begin
      bus1.tx_data  = d[DW1-1:0];
      bus1.shift_en = 1'b1;
    end else begin
      bus0.tx_data  = d[DW0-1:0];
      bus0.shift_en = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic stop(input bit which);
    @(negedge clk);
    if (which) bus1.shift_en = 1'b0;
    else bus0.shift_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Called just after a start edge; runs until shift_cmpt or a cycle bound.
  task automatic measure(input bit which, output int lat, output int cslow, output int nb,
                         output logic [31:0] seq, output int badper);
    logic [3:0] o;
    logic       ps;
    int         last_rise;
    int         half;
    half = which ? int'(CD1) : int'(CD0);
    lat = 0; cslow = 0; nb = 0; seq = '0; badper = 0; last_rise = -1;
    o = outs(which);
    if (o[3] == 1'b0) cslow++;
    ps = o[2];
    while (o[0] !== 1'b1 && lat < 1000) begin
      @(posedge clk);
      #1;
      lat++;
      o = outs(which);
      if (o[3] == 1'b0) cslow++;
      if (o[2] && !ps) begin
        seq = {seq[30:0], o[1]};
        nb++;
        if (last_rise >= 0 && (lat - last_rise) != 2 * half) badper++;
        last_rise = lat;
      end
      ps = o[2];
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_msb;   // rising-edge MOSI samples, first sample in bit 7
    logic [7:0] exp_lsb;
    int         hold;      // cycles shift_en stays high after shift_cmpt
  } vec_t;

  vec_t vecs[5];

  initial begin
    int          lat, cslow, nb, badper;
    logic [31:0] seq;
    logic [7:0]  exp8;

    vecs[0] = '{data: 8'hA5, exp_msb: 8'hA5, exp_lsb: 8'hA5, hold: 0};
    vecs[1] = '{data: 8'h01, exp_msb: 8'h01, exp_lsb: 8'h80, hold: 0};
    vecs[2] = '{data: 8'h2D, exp_msb: 8'h2D, exp_lsb: 8'hB4, hold: 5};
    vecs[3] = '{data: 8'hF0, exp_msb: 8'hF0, exp_lsb: 8'h0F, hold: 1};
    vecs[4] = '{data: 8'h00, exp_msb: 8'h00, exp_lsb: 8'h00, hold: 2};

    rst = 1'b1;
    bus0.shift_en = 1'b0; bus0.tx_data = '0;
    bus1.shift_en = 1'b0; bus1.tx_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_dut0", 32'(outs(0)), 32'h8);
    check("reset_dut1", 32'(outs(1)), 32'h8);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
`ifdef TSPI_TX_LSB_FIRST_EN
      exp8 = vecs[i].exp_lsb;
`else
      exp8 = vecs[i].exp_msb;
`endif
      start(1'b0, 32'(vecs[i].data));
      measure(1'b0, lat, cslow, nb, seq, badper);
      check("word_latency", lat, L0);
      check("word_cs_low", cslow, L0);
      check("word_nbits", nb, DW0);
      check("word_mosi_seq", 32'(seq[7:0]), 32'(exp8));
      check("word_sck_period", badper, 0);
      for (int h = 0; h < vecs[i].hold; h++) begin
        @(posedge clk);
        #1;
        check("hold_outputs", 32'(outs(0)), 32'h9);
      end
      stop(1'b0);
      check("cmpt_clear", 32'(outs(0)), 32'h8);
    end

    // Abort mid-word, then a fresh word two cycles later (5A reads the same in either order).
    start(1'b0, 32'h5A);
    repeat (19) @(posedge clk);
    @(negedge clk);
    bus0.shift_en = 1'b0;
    @(posedge clk);
    #1;
    check("abort_outputs", 32'(outs(0)), 32'h8);
    @(posedge clk);
    start(1'b0, 32'h5A);
    measure(1'b0, lat, cslow, nb, seq, badper);
    check("post_abort_latency", lat, L0);
    check("post_abort_seq", 32'(seq[7:0]), 32'h5A);
    stop(1'b0);

    // Reset mid-word with tx_data changed in flight; next word must carry the new value.
    start(1'b0, 32'h3C);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus0.tx_data = 8'hFF;
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_outputs", 32'(outs(0)), 32'h8);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    measure(1'b0, lat, cslow, nb, seq, badper);
    check("post_rst_latency", lat, L0);
    check("post_rst_seq", 32'(seq[7:0]), 32'hFF);
    stop(1'b0);

    // Fastest divider, wide word (8001 reads the same in either order).
    start(1'b1, 32'h8001);
    measure(1'b1, lat, cslow, nb, seq, badper);
    check("div1_latency", lat, L1);
    check("div1_cs_low", cslow, L1);
    check("div1_nbits", nb, DW1);
    check("div1_mosi_seq", 32'(seq[15:0]), 32'h8001);
    check("div1_sck_period", badper, 0);
    stop(1'b1);
    check("div1_cmpt_clear", 32'(outs(1)), 32'h8);

    // Randomized run on DUT0; the per-cycle model comparison does the checking.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 199) < 3) bus0.shift_en = ~bus0.shift_en;
      bus0.tx_data = DW0'($urandom);
      rst = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    bus0.shift_en = 1'b0;
    repeat (3) @(posedge clk);
    #2;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tspi_tx_shift.md
TSPI_TX_SHIFT -- requirements
Module: tspi_tx_shift

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the serial word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter CLK_DIV, default 4, giving the SCK half-period in clk cycles (legal range 1..255).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port clk, input, 1 bit: system clock; all flops on rising edge.
REQ-005 Port rst, input, 1 bit: synchronous active-high reset.
REQ-006 Port shift_en, input, 1 bit: level request from the TX controller; high = shift tx_data out, low = abort or idle.
REQ-007 Port tx_data, input, DATA_W bits: word to send; sampled only on the IDLE->SHIFT transition.
REQ-008 Port shift_cmpt, output, 1 bit: word fully shifted; held high until shift_en falls.
REQ-009 Port spi_cs_n, output, 1 bit: active-low chip select.
REQ-010 Port spi_sck, output, 1 bit: serial clock; SPI mode 0, idle low.
REQ-011 Port spi_mosi, output, 1 bit: serial data, changing only while SCK is low.

Function
REQ-012 The block SHALL implement three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE, a sampled shift_en=1 SHALL, on that edge, latch tx_data into the shift register, drive spi_cs_n=0, drive spi_mosi to the first bit, keep spi_sck=0, clear the divider and bit counters, and enter SHIFT.
REQ-014 In SHIFT, the divider SHALL count 0..CLK_DIV-1 and toggle spi_sck at each terminal count.
REQ-015 Each falling spi_sck edge that is not the last SHALL advance spi_mosi to the next bit.
REQ-016 The bit counter SHALL increment on each falling edge and be $clog2(DATA_W)+1 bits wide, so it never wraps.
REQ-017 The falling edge that completes bit DATA_W-1 SHALL, on that same edge, enter DONE with shift_cmpt=1, spi_cs_n=1, spi_sck=0 and spi_mosi=0.
REQ-018 The latency from the edge that samples shift_en high to shift_cmpt=1 SHALL be exactly 2*CLK_DIV*DATA_W cycles (64 at defaults).
REQ-019 In DONE, the block SHALL hold shift_cmpt=1 while shift_en=1; a sampled shift_en=0 SHALL clear shift_cmpt and enter IDLE.
REQ-020 After leaving DONE, the block SHALL spend at least one IDLE cycle before it can start a new word.
REQ-021 A shift_en=0 sampled in SHIFT SHALL abort on that edge: enter IDLE, spi_cs_n=1, spi_sck=0, spi_mosi=0, shift_cmpt stays 0.
REQ-022 Changes on tx_data while in SHIFT or DONE SHALL have no effect on the word in flight.
REQ-023 In IDLE, the outputs SHALL be spi_cs_n=1, spi_sck=0, spi_mosi=0 and shift_cmpt=0.

Reset
REQ-024 rst=1 SHALL force, on the next edge, state=IDLE, shift_cmpt=0, spi_cs_n=1, spi_sck=0, spi_mosi=0, and clear the divider, bit counter and shift register.
REQ-025 rst SHALL take priority over shift_en in every state, including mid-word; the partial word is discarded.
REQ-026 After rst deasserts, the block SHALL accept a new shift_en on the first following edge.

Configuration
REQ-027 With macro TSPI_TX_LSB_FIRST_EN defined, bits SHALL be sent LSB first (tx_data[0] first).
REQ-028 With TSPI_TX_LSB_FIRST_EN undefined, bits SHALL be sent MSB first (tx_data[DATA_W-1] first).
REQ-029 The macro SHALL affect only bit order; timing, handshake and ports are identical in both builds.

Verification
REQ-030 Defaults, MSB-first, tx_data=8'hA5, shift_en held high -> MOSI sampled on SCK rising edges reads 1,0,1,0,0,1,0,1; shift_cmpt rises 64 cycles after the start edge; spi_cs_n is low for exactly 64 cycles.
REQ-031 Defaults, LSB-first build, tx_data=8'hA5 -> rising-edge samples read 1,0,1,0,0,1,0,1 reversed (10100101 LSB first); same 64-cycle latency.
REQ-032 shift_en dropped at cycle 20 of a word -> next edge: spi_cs_n=1, spi_sck=0, no shift_cmpt; a new word started 2 cycles later completes normally.
REQ-033 shift_en held high for 5 cycles after shift_cmpt -> shift_cmpt stays high 5 cycles, clears on the edge sampling shift_en=0, and no second word starts.
REQ-034 rst pulsed at cycle 30 of a word, with tx_data changed mid-word to 8'hFF -> all outputs reach their idle values next edge; the following word sends the newly latched value.
REQ-035 CLK_DIV=1, DATA_W=16, tx_data=16'h8001 -> SCK period is 2 cycles; shift_cmpt appears after 32 cycles; MOSI sequence is 1, fourteen 0s, 1.
